// File: rtl/dcache_pkg.sv
// Shared geometry, tag-entry layout, FSM states and word helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned TAG_W     = 32 - IDX_W - OFFSET_W;
  localparam int unsigned ENTRY_W   = TAG_W + 2;
  localparam int unsigned VALID_BIT = 23;
  localparam int unsigned DIRTY_BIT = 22;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned WSEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITEBACK   = 2'd1,
    REFILL      = 2'd2,
    REFILL_DONE = 2'd3
  } state_t;

  function automatic logic [WORD_BITS-1:0] word_sel(
    input logic [LINE_BITS-1:0] line,
    input logic [WSEL_W-1:0]    sel
  );
    return line[sel*WORD_BITS +: WORD_BITS];
  endfunction

  function automatic logic [LINE_BITS-1:0] word_merge(
    input logic [LINE_BITS-1:0] line,
    input logic [WSEL_W-1:0]    sel,
    input logic [WORD_BITS-1:0] word
  );
    logic [LINE_BITS-1:0] merged;
    merged = line;
    merged[sel*WORD_BITS +: WORD_BITS] = word;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_wb_ctrl_if.sv
// Line-wide memory bus between the cache controller (master) and the
// backing data memory (slave): enable/ack handshake, one line per request.
interface dcache_wb_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) ();

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;

  modport master (
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_ack_i, mem_data_i
  );

  modport slave (
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_ack_i, mem_data_i
  );

endinterface

// File: rtl/dcache_sram.sv
// Single-port array with combinational read and synchronous write; the tag
// instance also clears every entry on a synchronous reset.
module dcache_sram #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned AW           = 5,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk_i) begin
    if (CLEAR_ON_RST && rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller:
// same-cycle hits, stall while a dirty victim is written back and the line refilled.
import dcache_pkg::*;

module dcache_wb_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  dcache_wb_ctrl_if.master  mem
);

  state_t state, w_next_state;

  logic                     r_mem_enable, w_mem_enable;
  logic                     r_mem_write, w_mem_write;
  logic [ADDR_W-1:0]        r_mem_addr, w_mem_addr;
  logic [LINE_W-1:0]        r_mem_data, w_mem_data;
  logic [ADDR_W-1:OFFSET_W] r_miss_line, w_miss_line;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_req_tag;
  logic [WSEL_W-1:0]  w_wsel;
  logic [ENTRY_W-1:0] w_tag_rd, w_tag_wdata;
  logic               w_tag_we;
  logic [LINE_W-1:0]  w_line, w_data_wdata;
  logic               w_data_we;
  logic               w_req, w_hit, w_victim_dirty;
  logic               sram_dirty;
  logic [WORD_W-1:0]  w_rdata;
  logic               w_stall;
  logic               w_unused;

  assign w_req     = p1_MemRead_i | p1_MemWrite_i;
  assign w_req_tag = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_wsel    = p1_addr_i[2 +: WSEL_W];
  assign w_unused  = &{1'b0, p1_addr_i[1:0]};

  // Outside IDLE the arrays are addressed by the latched miss line, so a
  // request that changes mid-miss cannot redirect the fill.
  assign w_idx = (state == IDLE) ? p1_addr_i[OFFSET_W +: IDX_W]
                                 : r_miss_line[OFFSET_W +: IDX_W];

  assign sram_dirty     = w_tag_rd[DIRTY_BIT];
  assign w_hit          = w_tag_rd[VALID_BIT] && (w_tag_rd[TAG_W-1:0] == w_req_tag);
  assign w_victim_dirty = w_tag_rd[VALID_BIT] && w_tag_rd[DIRTY_BIT];
  assign w_rdata        = word_sel(w_line, w_wsel);

  dcache_sram #(
    .WIDTH        (ENTRY_W),
    .AW           (IDX_W),
    .CLEAR_ON_RST (1'b1)
  ) dcache_tag_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_tag_we),
    .i_addr  (w_idx),
    .i_wdata (w_tag_wdata),
    .o_rdata (w_tag_rd)
  );

  dcache_sram #(
    .WIDTH        (LINE_W),
    .AW           (IDX_W),
    .CLEAR_ON_RST (1'b0)
  ) dcache_data_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_data_we),
    .i_addr  (w_idx),
    .i_wdata (w_data_wdata),
    .o_rdata (w_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_miss_line  <= '0;
    end else begin
      state        <= w_next_state;
      r_mem_enable <= w_mem_enable;
      r_mem_write  <= w_mem_write;
      r_mem_addr   <= w_mem_addr;
      r_mem_data   <= w_mem_data;
      r_miss_line  <= w_miss_line;
    end
  end

  always_comb begin
    w_next_state = state;
    w_mem_enable = r_mem_enable;
    w_mem_write  = r_mem_write;
    w_mem_addr   = r_mem_addr;
    w_mem_data   = r_mem_data;
    w_miss_line  = r_miss_line;
    w_tag_we     = 1'b0;
    w_tag_wdata  = '0;
    w_data_we    = 1'b0;
    w_data_wdata = w_line;
    w_stall      = 1'b0;
    p1_data_o    = '0;

    case (state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            if (p1_MemWrite_i) begin
              w_tag_we     = 1'b1;
              w_tag_wdata  = {1'b1, 1'b1, w_req_tag};
              w_data_we    = 1'b1;
              w_data_wdata = word_merge(w_line, w_wsel, p1_data_i);
            end else begin
              p1_data_o = w_rdata;
            end
          end else begin
            w_stall      = 1'b1;
            w_miss_line  = p1_addr_i[ADDR_W-1:OFFSET_W];
            w_mem_enable = 1'b1;
            if (w_victim_dirty) begin
              w_next_state = WRITEBACK;
              w_mem_write  = 1'b1;
              w_mem_addr   = {w_tag_rd[TAG_W-1:0], w_idx, {OFFSET_W{1'b0}}};
              w_mem_data   = w_line;
            end else begin
              w_next_state = REFILL;
              w_mem_write  = 1'b0;
              w_mem_addr   = {p1_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
          end
        end
      end
      WRITEBACK: begin
        w_stall = 1'b1;
        if (mem.mem_ack_i) begin
          w_next_state = REFILL;
          w_mem_write  = 1'b0;
          w_mem_addr   = {r_miss_line, {OFFSET_W{1'b0}}};
        end
      end
      REFILL: begin
        w_stall = 1'b1;
        if (mem.mem_ack_i) begin
          w_data_we    = 1'b1;
          w_data_wdata = mem.mem_data_i;
          w_tag_we     = 1'b1;
          w_tag_wdata  = {1'b1, 1'b0, r_miss_line[ADDR_W-1 -: TAG_W]};
          w_mem_enable = 1'b0;
          w_next_state = REFILL_DONE;
        end
      end
      REFILL_DONE: begin
        w_stall      = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign p1_stall_o       = w_stall;
  assign mem.mem_enable_o = r_mem_enable;
  assign mem.mem_write_o  = r_mem_write;
  assign mem.mem_addr_o   = r_mem_addr;
  assign mem.mem_data_o   = r_mem_data;

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl: line-granular memory responder with a
// fixed two-cycle latency and hand-computed expectations per scenario.
module tb_dcache_wb_ctrl;
  import dcache_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] data_o;
  logic        stall;

  int errors = 0;
  int checks = 0;

  int          n_rd = 0, n_wr = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;
  logic [255:0] mem_model [int unsigned];

  always #5 clk = ~clk;

  dcache_wb_ctrl_if mem_if ();

  dcache_wb_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_MemRead_i  (rd),
    .p1_MemWrite_i (wr),
    .p1_addr_i     (addr),
    .p1_data_i     (wdata),
    .p1_data_o     (data_o),
    .p1_stall_o    (stall),
    .mem           (mem_if)
  );

  // Memory: counts enable cycles, pulses ack for one cycle on the LAT-th.
  initial begin : responder
    int cnt;
    int unsigned line;
    cnt = 0;
    mem_if.mem_ack_i  = 1'b0;
    mem_if.mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_ack_i = 1'b0;
      if (mem_if.mem_enable_o) begin
        cnt++;
        if (cnt == LAT) begin
          cnt  = 0;
          line = mem_if.mem_addr_o >> 5;
          mem_if.mem_ack_i = 1'b1;
          if (mem_if.mem_write_o) begin
            mem_model[line] = mem_if.mem_data_o;
            n_wr++;
            last_wr_addr = mem_if.mem_addr_o;
            last_wr_data = mem_if.mem_data_o;
          end else begin
            mem_if.mem_data_i = mem_model[line];
            n_rd++;
            last_rd_addr = mem_if.mem_addr_o;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_stall(output int cyc);
    cyc = 1;
    while (stall && cyc < 60) begin
      @(negedge clk);
      #1;
      if (stall) cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (mem_if.mem_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", mem_if.mem_enable_o); end
    checks++; if (mem_if.mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", mem_if.mem_write_o); end
    checks++; if (mem_if.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_if.mem_addr_o); end
    checks++; if (mem_if.mem_data_o !== 256'h0) begin errors++; $display("FAIL reset_mdata: got %h want 0", mem_if.mem_data_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data_o: got %h want 0", data_o); end
    checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'h0) begin errors++; $display("FAIL reset_tag0: got %h want 0", dut.dcache_tag_sram.r_mem[0]); end
    checks++; if (dut.dcache_tag_sram.r_mem[31] !== 24'h0) begin errors++; $display("FAIL reset_tag31: got %h want 0", dut.dcache_tag_sram.r_mem[31]); end
    rst = 1'b0;
  endtask

  task automatic test_clean_read_miss;
    int cyc, rd0, wr0;
    @(negedge clk);
    rd0 = n_rd; wr0 = n_wr;
    rd = 1'b1; addr = 32'h0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL crm_stall_now: got %b want 1", stall); end
    wait_stall(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL crm_stall_cycles: got %0d want 4", cyc); end
    checks++; if (data_o !== 32'h5) begin errors++; $display("FAIL crm_data: got %h want 00000005", data_o); end
    checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'h800000) begin errors++; $display("FAIL crm_tag0: got %h want 800000", dut.dcache_tag_sram.r_mem[0]); end
    checks++; if (n_rd - rd0 != 1 || n_wr != wr0) begin errors++; $display("FAIL crm_traffic: got rd=%0d wr=%0d want rd=1 wr=0", n_rd - rd0, n_wr - wr0); end
    checks++; if (last_rd_addr !== 32'h0) begin errors++; $display("FAIL crm_rd_addr: got %h want 0", last_rd_addr); end
    checks++; if (mem_if.mem_enable_o !== 1'b0) begin errors++; $display("FAIL crm_enable_off: got %b want 0", mem_if.mem_enable_o); end
  endtask

  task automatic test_read_hit;
    @(negedge clk);
    rd = 1'b1; addr = 32'h4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rh_stall: got %b want 0", stall); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL rh_data: got %h want 0", data_o); end
    @(negedge clk);
    rd = 1'b0;
    #1;
    checks++; if (mem_if.mem_enable_o !== 1'b0) begin errors++; $display("FAIL rh_enable: got %b want 0", mem_if.mem_enable_o); end
  endtask

  task automatic test_write_hit;
    int rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    @(negedge clk);
    wr = 1'b1; addr = 32'h8; wdata = 32'hDEADBEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wh_stall: got %b want 0", stall); end
    checks++; if (dut.sram_dirty !== 1'b0) begin errors++; $display("FAIL wh_dirty_before: got %b want 0", dut.sram_dirty); end
    @(negedge clk);
    #1;
    checks++; if (dut.sram_dirty !== 1'b1) begin errors++; $display("FAIL wh_dirty_after: got %b want 1", dut.sram_dirty); end
    checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'hC00000) begin errors++; $display("FAIL wh_tag0: got %h want c00000", dut.dcache_tag_sram.r_mem[0]); end
    checks++; if (dut.dcache_data_sram.r_mem[0][95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL wh_word2: got %h want deadbeef", dut.dcache_data_sram.r_mem[0][95:64]); end
    checks++; if (dut.dcache_data_sram.r_mem[0][31:0] !== 32'h5) begin errors++; $display("FAIL wh_word0: got %h want 00000005", dut.dcache_data_sram.r_mem[0][31:0]); end
    checks++; if (n_rd != rd0 || n_wr != wr0 || mem_if.mem_enable_o !== 1'b0) begin errors++; $display("FAIL wh_no_traffic: got rd=%0d wr=%0d en=%b want 0 0 0", n_rd - rd0, n_wr - wr0, mem_if.mem_enable_o); end
    wr = 1'b0;
  endtask

  task automatic test_dirty_miss;
    int cyc, wr0;
    @(negedge clk);
    wr0 = n_wr;
    wr = 1'b0; rd = 1'b1; addr = 32'h400;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dm_stall_now: got %b want 1", stall); end
    wait_stall(cyc);
    checks++; if (cyc != 6) begin errors++; $display("FAIL dm_stall_cycles: got %0d want 6", cyc); end
    checks++; if (n_wr - wr0 != 1 || last_wr_addr !== 32'h0) begin errors++; $display("FAIL dm_wb_addr: got n=%0d addr=%h want n=1 addr=0", n_wr - wr0, last_wr_addr); end
    checks++; if (last_wr_data[31:0] !== 32'h5 || last_wr_data[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_wb_data: got w0=%h w2=%h want 00000005 deadbeef", last_wr_data[31:0], last_wr_data[95:64]); end
    checks++; if (last_rd_addr !== 32'h400) begin errors++; $display("FAIL dm_rd_addr: got %h want 00000400", last_rd_addr); end
    checks++; if (data_o !== 32'hA0000000) begin errors++; $display("FAIL dm_data: got %h want a0000000", data_o); end
    checks++; if (dut.dcache_tag_sram.r_mem[0] !== 24'h800001) begin errors++; $display("FAIL dm_tag0: got %h want 800001", dut.dcache_tag_sram.r_mem[0]); end
    checks++; if (dut.sram_dirty !== 1'b0) begin errors++; $display("FAIL dm_dirty: got %b want 0", dut.sram_dirty); end
  endtask

  task automatic test_write_miss;
    int cyc, wr0;
    @(negedge clk);
    wr0 = n_wr;
    rd = 1'b0; wr = 1'b1; addr = 32'h24; wdata = 32'h12345678;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wm_stall_now: got %b want 1", stall); end
    wait_stall(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL wm_stall_cycles: got %0d want 4", cyc); end
    checks++; if (n_wr != wr0 || last_rd_addr !== 32'h20) begin errors++; $display("FAIL wm_traffic: got wr=%0d rd_addr=%h want wr=0 rd_addr=00000020", n_wr - wr0, last_rd_addr); end
    @(negedge clk);
    wr = 1'b0;
    #1;
    checks++; if (dut.dcache_data_sram.r_mem[1][63:32] !== 32'h12345678) begin errors++; $display("FAIL wm_word1: got %h want 12345678", dut.dcache_data_sram.r_mem[1][63:32]); end
    checks++; if (dut.dcache_data_sram.r_mem[1][31:0] !== 32'h00001111) begin errors++; $display("FAIL wm_word0: got %h want 00001111", dut.dcache_data_sram.r_mem[1][31:0]); end
    checks++; if (dut.dcache_tag_sram.r_mem[1] !== 24'hC00000) begin errors++; $display("FAIL wm_tag1: got %h want c00000", dut.dcache_tag_sram.r_mem[1]); end
  endtask

  task automatic test_reset_mid_miss;
    int cyc;
    @(negedge clk);
    rd = 1'b1; addr = 32'h840;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmm_stall_now: got %b want 1", stall); end
    @(negedge clk);
    #1;
    checks++; if (dut.state !== REFILL || mem_if.mem_enable_o !== 1'b1) begin errors++; $display("FAIL rmm_in_refill: got state=%0d en=%b want 2 1", dut.state, mem_if.mem_enable_o); end
    rst = 1'b1; rd = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rmm_state: got %0d want 0", dut.state); end
    checks++; if (mem_if.mem_enable_o !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmm_en_stall: got en=%b stall=%b want 0 0", mem_if.mem_enable_o, stall); end
    checks++; if (dut.dcache_tag_sram.r_mem[2] !== 24'h0 || dut.dcache_tag_sram.r_mem[0] !== 24'h0) begin errors++; $display("FAIL rmm_tags: got t2=%h t0=%h want 0 0", dut.dcache_tag_sram.r_mem[2], dut.dcache_tag_sram.r_mem[0]); end
    rst = 1'b0;
    @(negedge clk);
    rd = 1'b1; addr = 32'h840;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmm_remiss: got %b want 1", stall); end
    wait_stall(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL rmm_stall_cycles: got %0d want 4", cyc); end
    checks++; if (data_o !== 32'h0BADF00D) begin errors++; $display("FAIL rmm_data: got %h want 0badf00d", data_o); end
    checks++; if (dut.dcache_tag_sram.r_mem[2] !== 24'h800002) begin errors++; $display("FAIL rmm_tag2: got %h want 800002", dut.dcache_tag_sram.r_mem[2]); end
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [255:0] l;
    mem_model[0] = 256'h5;
    l = '0;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA0000000 + w;
    mem_model[32] = l;
    mem_model[1]  = 256'h1111;
    mem_model[66] = 256'h0BADF00D;

    test_reset();
    test_clean_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_write_miss();
    test_reset_mid_miss();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
